em_reg: RTL
===========

EM_REG -- requirements
Module: em_reg

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, value of M_pc after reset.
REQ-002 SHALL have parameter EXC_PC, default 32'h0000_4180, value loaded into M_pc on exception/interrupt request.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  1 = load from E stage; 0 = hold current contents.
REQ-006 SHALL have port flush  input  1  insert bubble, keeping M_pc/M_bd.
REQ-007 SHALL have port req  input  1  exception/interrupt taken; clear stage, M_pc=EXC_PC.
REQ-008 SHALL have E-side inputs E_instr 32, E_pc 32, E_alu 32, E_wdata 32, E_regaddr 5, E_Tnew 2, E_excode 5, E_bd 1.
REQ-009 SHALL have M-side outputs M_instr 32, M_pc 32, M_alu 32, M_wdata 32, M_regaddr 5, M_Tnew 2, M_excode 5, M_bd 1, M_valid 1.
REQ-010 M_instr SHALL drive the instruction port of the M-stage hazard decoder; M_Tnew SHALL be this block's own registered value.

Function
REQ-011 Update priority each rising edge SHALL be: req > flush > !en (hold) > load.
REQ-012 Load SHALL copy every E_* input to its M_* register in one cycle (latency 1), M_valid=1.
REQ-013 On load M_Tnew SHALL be E_Tnew-1 saturating at 0 (E_Tnew=0 -> 0, 2 -> 1, 3 -> 2).
REQ-014 On load with E_instr==0 (nop) M_valid SHALL be 0 and M_regaddr SHALL be forced to 0.
REQ-015 Hold (en=0, no req/flush) SHALL keep all registers unchanged, including M_Tnew.
REQ-016 Flush SHALL clear M_instr, M_alu, M_wdata, M_regaddr, M_Tnew, M_excode, M_valid to 0 and load M_pc=E_pc, M_bd=E_bd, so exception PC/BD reporting survives the bubble.
REQ-017 Flush SHALL take effect even when en=0.
REQ-018 req SHALL clear all registers to 0 except M_pc=EXC_PC; E inputs ignored that cycle.
REQ-019 req and flush asserted together SHALL behave as req alone.
REQ-020 M_regaddr==0 SHALL never be reported with M_valid=1 as a register write target; M_regaddr forced 0 whenever M_valid=0.
REQ-021 M_excode SHALL pass E_excode unchanged on load; this block SHALL not generate exception codes.
REQ-022 All outputs SHALL be direct register outputs, no combinational path from any input to any output.

Reset
REQ-023 reset low SHALL immediately (asynchronously) force M_pc=RESET_PC and all other outputs to 0, M_valid=0.
REQ-024 reset deassertion SHALL take effect on the next rising clk; the first edge with reset high obeys REQ-011.
REQ-025 reset asserted mid-hold or mid-flush SHALL override; no prior content survives.

Structure
REQ-026 Opcode/funct constants, excode values, RESET_PC and EXC_PC defaults SHALL come from the shared define file used by all stage decoders.
REQ-027 A single sub-module, pipe_field_reg (parameterised width, reset value, en/clear), SHALL be instantiated per field; no other sub-modules.

Verification
REQ-028 reset low mid-cycle -> outputs change before next edge: M_pc=32'h3000, M_instr=0, M_valid=0.
REQ-029 en=1, E_instr=lw (0x8C430004), E_pc=32'h3008, E_Tnew=2 -> next cycle M_instr=0x8C430004, M_pc=32'h3008, M_Tnew=1, M_valid=1.
REQ-030 en=0 for 3 cycles after REQ-029 load, E inputs changing -> M_* constant, M_Tnew=1 throughout.
REQ-031 flush=1, en=0, E_pc=32'h300C, E_bd=1 -> M_instr=0, M_Tnew=0, M_valid=0, M_pc=32'h300C, M_bd=1.
REQ-032 req=1 and flush=1 same edge, E_pc=32'h3010 -> M_pc=32'h4180, M_bd=0, all else 0.
REQ-033 E_instr=0, E_regaddr=5'd7, E_Tnew=0, en=1 -> M_valid=0, M_regaddr=0, M_Tnew=0.

Source files
------------

// File: rtl/em_reg_pkg.sv
// Shared pipeline constants: default PCs, opcode/funct and exception codes
// used by every stage decoder, plus the Tnew ageing helper.
package em_reg_pkg;

  localparam logic [31:0] EM_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EM_EXC_PC   = 32'h0000_4180;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_COP0  = 6'b010000;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ERET = 6'b011000;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // One stage of ageing for the result-ready countdown, floored at zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/em_reg_pipe_field_reg.sv
// Single pipeline field register: async reset value, synchronous clear
// (to a fixed value) taking priority over load-enable.
module pipe_field_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear beats load; neither asserted holds the current value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_q <= RST_VAL;
    else if (i_clr) r_q <= CLR_VAL;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/em_reg.sv
// E/M pipeline register. Priority per edge: req > flush > hold > load.
// Flush leaves a bubble but still captures E_pc/E_bd so a later exception
// on the bubble reports the right PC and delay-slot flag.
module em_reg
  import em_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = EM_RESET_PC,
  parameter logic [31:0] EXC_PC   = EM_EXC_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        req,
  input  logic [31:0] E_instr,
  input  logic [31:0] E_pc,
  input  logic [31:0] E_alu,
  input  logic [31:0] E_wdata,
  input  logic [4:0]  E_regaddr,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  E_excode,
  input  logic        E_bd,
  output logic [31:0] M_instr,
  output logic [31:0] M_pc,
  output logic [31:0] M_alu,
  output logic [31:0] M_wdata,
  output logic [4:0]  M_regaddr,
  output logic [1:0]  M_Tnew,
  output logic [4:0]  M_excode,
  output logic        M_bd,
  output logic        M_valid
);

  logic        w_nop;
  logic        w_bub_clr;
  logic        w_side_en;
  logic [4:0]  w_regaddr;
  logic [1:0]  w_tnew;
  logic        w_valid;

  // Load-side data shaping: nops never carry a write target.
  always_comb begin
    w_nop     = (E_instr == '0);
    w_regaddr = w_nop ? 5'd0 : E_regaddr;
    w_tnew    = tnew_dec(E_Tnew);
    w_valid   = ~w_nop;
  end

  // PC/BD fields treat flush as a load and req as a clear (req wins inside
  // the field register); every other field treats both as a clear.
  assign w_bub_clr = req | flush;
  assign w_side_en = en | flush;

  pipe_field_reg #(.WIDTH(32), .RST_VAL(RESET_PC), .CLR_VAL(EXC_PC)) u_pc (
    .clk(clk), .rst_n(reset), .i_en(w_side_en), .i_clr(req), .i_d(E_pc), .o_q(M_pc));

  pipe_field_reg #(.WIDTH(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_bd (
    .clk(clk), .rst_n(reset), .i_en(w_side_en), .i_clr(req), .i_d(E_bd), .o_q(M_bd));

  pipe_field_reg #(.WIDTH(32), .RST_VAL('0), .CLR_VAL('0)) u_instr (
    .clk(clk), .rst_n(reset), .i_en(en), .i_clr(w_bub_clr), .i_d(E_instr), .o_q(M_instr));

  pipe_field_reg #(.WIDTH(32), .RST_VAL('0), .CLR_VAL('0)) u_alu (
    .clk(clk), .rst_n(reset), .i_en(en), .i_clr(w_bub_clr), .i_d(E_alu), .o_q(M_alu));

  pipe_field_reg #(.WIDTH(32), .RST_VAL('0), .CLR_VAL('0)) u_wdata (
    .clk(clk), .rst_n(reset), .i_en(en), .i_clr(w_bub_clr), .i_d(E_wdata), .o_q(M_wdata));

  pipe_field_reg #(.WIDTH(5), .RST_VAL('0), .CLR_VAL('0)) u_regaddr (
    .clk(clk), .rst_n(reset), .i_en(en), .i_clr(w_bub_clr), .i_d(w_regaddr), .o_q(M_regaddr));

  pipe_field_reg #(.WIDTH(2), .RST_VAL('0), .CLR_VAL('0)) u_tnew (
    .clk(clk), .rst_n(reset), .i_en(en), .i_clr(w_bub_clr), .i_d(w_tnew), .o_q(M_Tnew));

  pipe_field_reg #(.WIDTH(5), .RST_VAL('0), .CLR_VAL('0)) u_excode (
    .clk(clk), .rst_n(reset), .i_en(en), .i_clr(w_bub_clr), .i_d(E_excode), .o_q(M_excode));

  pipe_field_reg #(.WIDTH(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_valid (
    .clk(clk), .rst_n(reset), .i_en(en), .i_clr(w_bub_clr), .i_d(w_valid), .o_q(M_valid));

endmodule
